// File: rtl/pdh_pid.sv
// Three-stage PID loop filter for a Pound-Drever-Hall lock.
// Signed error in, offset-binary DAC code out, with integrator and output clamping.
module pdh_pid #(
  parameter int DATA_WIDTH     = 16,
  parameter int DAC_DATA_WIDTH = 14,
  parameter int GAIN_WIDTH     = 16,
  parameter int GAIN_SHIFT     = 10,
  parameter int ACC_WIDTH      = 40
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [DATA_WIDTH-1:0]      err_i,
  input  logic                              err_valid_i,
  input  logic signed [DATA_WIDTH-1:0]      setpoint_i,
  input  logic signed [GAIN_WIDTH-1:0]      kp_i,
  input  logic signed [GAIN_WIDTH-1:0]      ki_i,
  input  logic signed [GAIN_WIDTH-1:0]      kd_i,
  input  logic                              enable_i,
  output logic        [DAC_DATA_WIDTH-1:0]  dac_code_o,
  output logic                              dac_valid_o,
  output logic                              sat_o,
  output logic        [1:0]                 state_o
);

  localparam int E_W   = DATA_WIDTH + 1;
  localparam int DE_W  = DATA_WIDTH + 2;
  localparam int P_W   = GAIN_WIDTH + E_W;
  localparam int D_W   = GAIN_WIDTH + DE_W;
  localparam int SUM_W = ((ACC_WIDTH > D_W) ? ACC_WIDTH : D_W) + 2;
  localparam int ACC_N = ACC_WIDTH + 1;

  localparam logic signed [ACC_N-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_N-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] DAC_MAX = SUM_W'((2 ** (DAC_DATA_WIDTH-1)) - 1);
  localparam logic signed [SUM_W-1:0] DAC_MIN = ~DAC_MAX;
  localparam logic [DAC_DATA_WIDTH-1:0] DAC_MID = {1'b1, {(DAC_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_N-1:0] x);
    if (x > ACC_MAX)      return ACC_WIDTH'(ACC_MAX);
    else if (x < ACC_MIN) return ACC_WIDTH'(ACC_MIN);
    else                  return ACC_WIDTH'(x);
  endfunction

  // Returns {clamp_hit, offset_binary_code}; offset binary is two's complement with MSB inverted.
  function automatic logic [DAC_DATA_WIDTH:0] sat_dac(input logic signed [SUM_W-1:0] s);
    logic [DAC_DATA_WIDTH-1:0] c;
    logic                      hit;
    hit = 1'b1;
    if (s > DAC_MAX)      c = DAC_DATA_WIDTH'(DAC_MAX);
    else if (s < DAC_MIN) c = DAC_DATA_WIDTH'(DAC_MIN);
    else begin
      c   = DAC_DATA_WIDTH'(s);
      hit = 1'b0;
    end
    return {hit, ~c[DAC_DATA_WIDTH-1], c[DAC_DATA_WIDTH-2:0]};
  endfunction

  state_t state, state_n;
  logic   accept;
  logic   flush;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    flush   = !enable_i;
    case (state)
      OFF:   if (enable_i) state_n = PRIME;
      PRIME: begin
        accept = err_valid_i && enable_i;
        if (accept) state_n = RUN;
      end
      RUN:     accept = err_valid_i && enable_i;
      default: state_n = OFF;
    endcase
    if (!enable_i) state_n = OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_n;
  end

  assign state_o = state;

  // Stage 1: error and first difference
  logic signed [E_W-1:0]  e_c, e_prev, e_p0;
  logic signed [DE_W-1:0] de_c, de_p0;
  logic                   vld_p0;

  always_comb begin
    e_c  = E_W'(setpoint_i) - E_W'(err_i);
    de_c = DE_W'(e_c) - DE_W'(e_prev);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p0 <= 1'b0;
      e_prev <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) e_prev <= e_c;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      e_p0  <= e_c;
      de_p0 <= (state == PRIME) ? '0 : de_c;
    end
  end

  // Stage 2: products and integrator; gains are taken live here
  logic signed [P_W-1:0]       kie_c;
  logic signed [ACC_N-1:0]     acc_sum_c;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [P_W-1:0]       p_p1;
  logic signed [D_W-1:0]       d_p1;
  logic                        vld_p1;

  always_comb begin
    kie_c     = P_W'(ki_i) * P_W'(e_p0);
    acc_sum_c = ACC_N'(acc) + ACC_N'(kie_c);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1 <= 1'b0;
      acc    <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) acc <= sat_acc(acc_sum_c);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      p_p1 <= P_W'(kp_i) * P_W'(e_p0);
      d_p1 <= D_W'(kd_i) * D_W'(de_p0);
    end
  end

  // Stage 3: sum, scale, clamp; acc already holds this sample's integral term
  logic signed [SUM_W-1:0]    sum_c, shr_c;
  logic [DAC_DATA_WIDTH-1:0]  code_c;
  logic                       sat_c;
  logic [DAC_DATA_WIDTH-1:0]  dac_code_p2;
  logic                       sat_p2;
  logic                       vld_p2;

  always_comb begin
    sum_c           = SUM_W'(p_p1) + SUM_W'(d_p1) + SUM_W'(acc);
    shr_c           = sum_c >>> GAIN_SHIFT;
    {sat_c, code_c} = sat_dac(shr_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      dac_code_p2 <= DAC_MID;
      sat_p2      <= 1'b0;
    end else if (flush) begin
      vld_p2      <= 1'b0;
      dac_code_p2 <= DAC_MID;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        dac_code_p2 <= code_c;
        sat_p2      <= sat_c;
      end
    end
  end

  assign dac_code_o  = dac_code_p2;
  assign dac_valid_o = vld_p2;
  assign sat_o       = sat_p2;

endmodule

// File: tb/tb_pdh_pid.sv
// Bench for pdh_pid: directed vector table, corner sequences, and random traffic
// checked every cycle against a cycle-history reference model.
module tb_pdh_pid;

  logic clk;
  logic rst, en, vld;
  logic signed [15:0] err, sp, kp, ki, kd;
  logic [13:0] code;
  logic dvld, sat;
  logic [1:0] st;

  int total = 0;
  int bad   = 0;

  pdh_pid dut (
    .clk(clk), .rst(rst), .err_i(err), .err_valid_i(vld), .setpoint_i(sp),
    .kp_i(kp), .ki_i(ki), .kd_i(kd), .enable_i(en),
    .dac_code_o(code), .dac_valid_o(dvld), .sat_o(sat), .state_o(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each edge is recorded; a sample accepted at edge n emits at
  // edge n+2 using the gains present at edge n+1, unless a kill edge intervenes.
  typedef struct {
    bit     kill;
    bit     acc;
    longint e, de, kp, ki, kd;
  } edge_t;

  localparam longint ACCM = (longint'(1) <<< 39) - 1;

  edge_t  hist[4];
  int     mst = 0;
  longint m_eprev = 0, m_acc = 0, m_code = 8192;
  bit     m_vld = 0, m_sat = 0;
  int     n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    edge_t  h, h1, h2;
    longint e, s, sum;
    h1 = hist[(n + 3) % 4];
    h2 = hist[(n + 2) % 4];
    e  = longint'(sp) - longint'(err);
    h.kill = rst || !en;
    h.acc  = !h.kill && vld && (mst != 0);
    h.e    = e;
    h.de   = (mst == 1) ? 0 : e - m_eprev;
    h.kp   = longint'(kp);
    h.ki   = longint'(ki);
    h.kd   = longint'(kd);
    m_vld  = 0;
    if (rst) begin
      m_acc = 0; m_code = 8192; m_sat = 0;
    end else if (!en) begin
      m_acc = 0; m_code = 8192;
    end else if (h2.acc && !h1.kill) begin
      m_acc = m_acc + h1.ki * h2.e;
      if (m_acc > ACCM) m_acc = ACCM;
      if (m_acc < -ACCM) m_acc = -ACCM;
      sum   = h1.kp * h2.e + m_acc + h1.kd * h2.de;
      s     = sum >>> 10;
      m_sat = (s > 8191) || (s < -8192);
      if (s > 8191) s = 8191;
      if (s < -8192) s = -8192;
      m_code = s + 8192;
      m_vld  = 1;
    end
    if (h.kill) begin
      m_eprev = 0; mst = 0;
    end else begin
      if (h.acc) m_eprev = e;
      if (mst == 0) mst = 1;
      else if (mst == 1 && h.acc) mst = 2;
    end
    hist[n % 4] = h;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_valid", 32'(dvld), 32'(m_vld));
    chk("m_code",  32'(code), 32'(m_code));
    chk("m_sat",   32'(sat),  32'(m_sat));
    chk("m_state", 32'(st),   32'(mst));
    n++;
  endtask

  task automatic restart();
    en = 0; vld = 0; step();
    en = 1; step();
  endtask

  typedef struct {
    bit restart;
    int kp, ki, kd, sp, err;
    int code;
    bit sat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1; en = 0; vld = 0; err = 0; sp = 0; kp = 0; ki = 0; kd = 0;
    step();
    step();
    chk("rst_code",  32'(code), 32'd8192);
    chk("rst_valid", 32'(dvld), 32'd0);
    chk("rst_sat",   32'(sat),  32'd0);
    chk("rst_state", 32'(st),   32'd0);
    rst = 0;

    //          rst kp     ki    kd    sp      err     code   sat
    tbl[0]  = '{1, 1024,  0,    0,    0,      100,    8092,  0};
    tbl[1]  = '{1, 0,     1024, 0,    0,      -10,    8202,  0};
    tbl[2]  = '{0, 0,     1024, 0,    0,      -10,    8212,  0};
    tbl[3]  = '{0, 0,     1024, 0,    0,      -10,    8222,  0};
    tbl[4]  = '{0, 0,     1024, 0,    0,      -10,    8232,  0};
    tbl[5]  = '{0, 0,     1024, 0,    0,      -10,    8242,  0};
    tbl[6]  = '{1, 0,     0,    1024, 0,      -50,    8192,  0};
    tbl[7]  = '{0, 0,     0,    1024, 0,      -80,    8222,  0};
    tbl[8]  = '{1, 32767, 0,    0,    32767,  -32768, 16383, 1};
    tbl[9]  = '{1, 32767, 0,    0,    -32768, 32767,  0,     1};
    tbl[10] = '{1, 1024,  0,    0,    0,      0,      8192,  0};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].restart) restart();
      kp = 16'(tbl[i].kp); ki = 16'(tbl[i].ki); kd = 16'(tbl[i].kd);
      sp = 16'(tbl[i].sp); err = 16'(tbl[i].err); vld = 1;
      step();
      vld = 0;
      chk("tbl_lat1", 32'(dvld), 32'd0);
      step();
      chk("tbl_lat2", 32'(dvld), 32'd0);
      step();
      chk("tbl_valid", 32'(dvld), 32'd1);
      chk("tbl_code",  32'(code), 32'(tbl[i].code));
      chk("tbl_sat",   32'(sat),  32'(tbl[i].sat));
    end

    // Reset mid-RUN with a nonzero integrator, then re-enable
    restart();
    kp = 0; ki = 1024; kd = 0; sp = 0; err = -100; vld = 1;
    repeat (4) step();
    rst = 1;
    step();
    chk("rst_run_code",  32'(code), 32'd8192);
    chk("rst_run_valid", 32'(dvld), 32'd0);
    chk("rst_run_state", 32'(st),   32'd0);
    rst = 0; vld = 0;
    step();
    kd = 1024; err = -10; vld = 1;
    step();
    vld = 0;
    step();
    step();
    chk("reprime_valid", 32'(dvld), 32'd1);
    chk("reprime_code",  32'(code), 32'd8202);

    // Enable drop with samples in flight
    restart();
    kp = 1024; ki = 0; kd = 0; sp = 0; err = 100; vld = 1;
    step();
    vld = 0;
    step();
    step();
    chk("pre_drop_code", 32'(code), 32'd8092);
    err = 100; vld = 1; step();
    err = 200; step();
    en = 0; err = 300; step();
    chk("drop_code",  32'(code), 32'd8192);
    chk("drop_valid", 32'(dvld), 32'd0);
    chk("drop_state", 32'(st),   32'd0);
    vld = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_quiet", 32'(dvld), 32'd0);
    end

    // Gain change lands on the sample entering the multiply stage
    restart();
    kp = 1024; ki = 0; kd = 0; sp = 0; err = 100; vld = 1;
    step();
    vld = 0; kp = 2048;
    step();
    step();
    chk("gain_valid", 32'(dvld), 32'd1);
    chk("gain_code",  32'(code), 32'd7992);

    // Random traffic against the reference model
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) en = !en;
      vld = ($urandom_range(0, 3) != 0);
      err = 16'($urandom);
      if ($urandom_range(0, 7) == 0) sp = 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        kp = 16'(int'($urandom_range(0, 4095)) - 2048);
        ki = 16'(int'($urandom_range(0, 255)) - 128);
        kd = 16'(int'($urandom_range(0, 1023)) - 512);
      end
      if ($urandom_range(0, 99) == 0) kp = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
